// File: rtl/minitb_ahb_pkg.sv
// Shared AHB-Lite encodings and the helper that derives the largest legal
// hsize for a given bus width.
package minitb_ahb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        HSIZE_BYTE  = 3'd0,
        HSIZE_HALF  = 3'd1,
        HSIZE_WORD  = 3'd2,
        HSIZE_DWORD = 3'd3,
        HSIZE_4WORD = 3'd4,
        HSIZE_8WORD = 3'd5,
        HSIZE_512   = 3'd6,
        HSIZE_1024  = 3'd7
    } hsize_t;

    // log2(data_width/8); usable in localparam context
    function automatic logic [2:0] max_hsize(input int unsigned data_width);
        logic [2:0] size;
        size = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if ((32'd8 << i) == data_width) begin
                size = 3'(i);
            end
        end
        return size;
    endfunction

endpackage

// File: rtl/minitb_sync_fifo.sv
// Single-clock FIFO with occupancy count; push is honoured when full only if
// a pop happens on the same edge.
module minitb_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/minitb_ahb_master_pipe.sv
// Pipelined AHB-Lite master: cmd FIFO -> address stage -> data stage -> rsp FIFO.
// Define MINITB_AHB_MASTER_HRESP_EN to add the hresp port and two-cycle ERROR handling.
module minitb_ahb_master_pipe
    import minitb_ahb_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                  hclk,
    input  logic                  hresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [1:0]            htrans,
    output logic [ADDR_WIDTH-1:0] haddr,
    output logic                  hwrite,
    output logic [2:0]            hsize,
    output logic [DATA_WIDTH-1:0] hwdata,
    input  logic [DATA_WIDTH-1:0] hrdata,
`ifdef MINITB_AHB_MASTER_HRESP_EN
    input  logic                  hresp,
`endif
    input  logic                  hready
);

    localparam logic [2:0] MAX_SIZE = max_hsize(DATA_WIDTH);
    localparam int CMD_W = 1 + ADDR_WIDTH + 3 + DATA_WIDTH;
    localparam int RSP_W = 1 + DATA_WIDTH + 1;
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] ALMOST_FULL = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_EXT   = (CNT_W+1)'(DEPTH);

    // command FIFO
    logic              cmd_push;
    logic              cmd_pop;
    logic [CMD_W-1:0]  cmd_din;
    logic [CMD_W-1:0]  cmd_dout;
    logic              cmd_full;
    logic              cmd_empty;
    logic [CNT_W-1:0]  cmd_count;
    logic              cmd_full_next;

    // response FIFO
    logic              rsp_push;
    logic              rsp_pop;
    logic [RSP_W-1:0]  rsp_din;
    logic [RSP_W-1:0]  rsp_dout;
    logic              rsp_full;
    logic              rsp_empty;
    logic [CNT_W-1:0]  rsp_count;

    // head of command FIFO
    logic                  head_write;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [2:0]            head_size;
    logic [DATA_WIDTH-1:0] head_wdata;
    logic                  head_legal;

    // pipeline stages
    htrans_t               htrans_q;
    hsize_t                hsize_q;
    logic                  a_valid;
    logic                  a_supp;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  d_valid;
    logic                  d_write;

    logic                  bus_err;
    logic                  err_first;
    logic                  a_leave;
    logic                  a_retry;
    logic                  a_cancel;
    logic                  a_free;
    logic [CNT_W:0]        occupancy;
    logic                  issue;
    logic                  bypass;
    logic                  d_done;
    logic [DATA_WIDTH-1:0] d_rdata;

`ifdef MINITB_AHB_MASTER_HRESP_EN
    assign bus_err = hresp;
`else
    assign bus_err = 1'b0;
`endif

    assign cmd_push = cmd_valid && cmd_ready;
    assign cmd_din  = {cmd_write, cmd_addr, cmd_size, cmd_wdata};
    assign {head_write, head_addr, head_size, head_wdata} = cmd_dout;
    assign head_legal = (head_size <= MAX_SIZE);

    minitb_sync_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (DEPTH)
    ) u_cmd_fifo (
        .clk   (hclk),
        .rst_n (hresetn),
        .push  (cmd_push),
        .pop   (cmd_pop),
        .wdata (cmd_din),
        .rdata (cmd_dout),
        .full  (cmd_full),
        .empty (cmd_empty),
        .count (cmd_count)
    );

    // cmd_ready is registered, so it must reflect the occupancy after this edge
    assign cmd_full_next = (cmd_full && !(cmd_pop && !cmd_push)) ||
                           ((cmd_count == ALMOST_FULL) && cmd_push && !cmd_pop);

    // First ERROR cycle suppresses the pending address phase; it re-drives on the next hready.
    assign err_first = d_valid && bus_err && !hready;
    assign a_leave   = a_valid && !a_supp && hready;
    assign a_retry   = a_valid && a_supp && hready;
    assign a_cancel  = a_valid && !a_supp && err_first;
    assign a_free    = !a_valid || a_leave;
    assign occupancy = {1'b0, rsp_count} + (CNT_W+1)'(a_valid) + (CNT_W+1)'(d_valid);

    assign issue  = !cmd_empty && head_legal && a_free && !err_first && (occupancy < DEPTH_EXT);
    // Oversized commands wait for the pipeline to drain so their error stays in order.
    assign bypass = !cmd_empty && !head_legal && !a_valid && !d_valid && !rsp_full;
    assign cmd_pop = issue || bypass;

    assign d_done   = d_valid && hready;
    assign rsp_push = d_done || bypass;
    assign rsp_pop  = rsp_valid && rsp_ready;

    always_comb begin
        d_rdata = hrdata;
        if (d_write || bus_err) begin
            d_rdata = '0;
        end
        if (d_done) begin
            rsp_din = {d_write, d_rdata, bus_err};
        end else begin
            rsp_din = {head_write, {DATA_WIDTH{1'b0}}, 1'b1};
        end
    end

    minitb_sync_fifo #(
        .WIDTH (RSP_W),
        .DEPTH (DEPTH)
    ) u_rsp_fifo (
        .clk   (hclk),
        .rst_n (hresetn),
        .push  (rsp_push),
        .pop   (rsp_pop),
        .wdata (rsp_din),
        .rdata (rsp_dout),
        .full  (rsp_full),
        .empty (rsp_empty),
        .count (rsp_count)
    );

    assign rsp_valid = !rsp_empty;
    assign {rsp_write, rsp_rdata, rsp_err} = rsp_empty ? '0 : rsp_dout;

    assign htrans = htrans_q;
    assign hsize  = hsize_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cmd_ready <= 1'b0;
            htrans_q  <= HTRANS_IDLE;
            haddr     <= '0;
            hwrite    <= 1'b0;
            hsize_q   <= HSIZE_BYTE;
            a_valid   <= 1'b0;
            a_supp    <= 1'b0;
            a_wdata   <= '0;
            d_valid   <= 1'b0;
            d_write   <= 1'b0;
            hwdata    <= '0;
        end else begin
            cmd_ready <= !cmd_full_next;

            if (issue) begin
                a_valid  <= 1'b1;
                a_supp   <= 1'b0;
                htrans_q <= HTRANS_NONSEQ;
                haddr    <= head_addr;
                hwrite   <= head_write;
                hsize_q  <= hsize_t'(head_size);
                a_wdata  <= head_wdata;
            end else if (a_leave) begin
                a_valid  <= 1'b0;
                htrans_q <= HTRANS_IDLE;
            end else if (a_cancel) begin
                a_supp   <= 1'b1;
                htrans_q <= HTRANS_IDLE;
            end else if (a_retry) begin
                a_supp   <= 1'b0;
                htrans_q <= HTRANS_NONSEQ;
            end

            if (hready) begin
                d_valid <= a_leave;
                d_write <= hwrite;
                if (a_leave && hwrite) begin
                    hwdata <= a_wdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_minitb_ahb_master_pipe.sv
// Directed scoreboard bench for minitb_ahb_master_pipe; the slave returns addr/4+1
// on reads. Error-response vectors build only with MINITB_AHB_MASTER_HRESP_EN.
module tb_minitb_ahb_master_pipe;

    logic        hclk = 1'b0;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [7:0]  cmd_addr;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  htrans;
    logic [7:0]  haddr;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] hwdata;
    logic [31:0] hrdata;
    logic        hready;
`ifdef MINITB_AHB_MASTER_HRESP_EN
    logic        hresp;
`endif

    minitb_ahb_master_pipe #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .DEPTH      (4)
    ) dut (
        .hclk      (hclk),
        .hresetn   (hresetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_write (rsp_write),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .htrans    (htrans),
        .haddr     (haddr),
        .hwrite    (hwrite),
        .hsize     (hsize),
        .hwdata    (hwdata),
        .hrdata    (hrdata),
`ifdef MINITB_AHB_MASTER_HRESP_EN
        .hresp     (hresp),
`endif
        .hready    (hready)
    );

    always #5 hclk = ~hclk;

    typedef struct packed {
        logic        w;
        logic [31:0] d;
        logic        e;
    } rsp_t;

    rsp_t     exp_q[$];
    logic [7:0] bus_addr[$];
    int       bus_cyc[$];
    int       cyc = 0;
    int       checks = 0;
    int       passes = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    // slave model: data-phase tracking, sampled on negedge, committed on posedge
    logic       dp_valid, dp_write, nx_valid, nx_write;
    logic [7:0] dp_addr, nx_addr;
    initial begin
        nx_valid = 1'b0;
        nx_write = 1'b0;
        nx_addr  = '0;
    end
    always @(negedge hclk) begin
        if (hready) begin
            nx_valid = (htrans == 2'b10);
            nx_write = hwrite;
            nx_addr  = haddr;
        end else begin
            nx_valid = dp_valid;
            nx_write = dp_write;
            nx_addr  = dp_addr;
        end
    end
    always @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dp_valid <= 1'b0;
            dp_write <= 1'b0;
            dp_addr  <= '0;
        end else begin
            dp_valid <= nx_valid;
            dp_write <= nx_write;
            dp_addr  <= nx_addr;
        end
    end
    assign hrdata = (dp_valid && !dp_write) ? 32'(dp_addr >> 2) + 32'd1 : 32'd0;

    always @(posedge hclk) cyc++;

    // bus log: one entry per completed NONSEQ address phase
    always @(negedge hclk) begin
        if (hresetn === 1'b1 && hready && htrans == 2'b10) begin
            bus_addr.push_back(haddr);
            bus_cyc.push_back(cyc);
        end
    end

    // response monitor
    always @(negedge hclk) begin
        if (hresetn === 1'b1 && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL rsp_unexpected: got w=%0b rdata=%0h err=%0b expected no response",
                         rsp_write, rsp_rdata, rsp_err);
            end else begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp", 64'({rsp_write, rsp_rdata, rsp_err}), 64'(e));
            end
        end
    end

    task automatic send(input logic w, input logic [7:0] a, input logic [2:0] s,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input bit track);
        bit   acc;
        rsp_t t;
        acc       = 1'b0;
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_size  = s;
        cmd_wdata = wd;
        if (track) begin
            t.w = w;
            t.d = er;
            t.e = ee;
            exp_q.push_back(t);
        end
        for (int i = 0; i < 200; i++) begin
            @(negedge hclk);
            if (cmd_ready) begin
                acc = 1'b1;
                break;
            end
        end
        if (acc) begin
            tick();
        end else begin
            checks++;
            $display("FAIL cmd_accept_timeout: addr %0h not accepted within 200 cycles", a);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_q.size() == 0 && !rsp_valid && htrans == 2'b00) break;
        end
        check("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = '0;
        cmd_size  = '0;
        cmd_wdata = '0;
        rsp_ready = 1'b1;
        hready    = 1'b1;
`ifdef MINITB_AHB_MASTER_HRESP_EN
        hresp     = 1'b0;
`endif
        tick();
        tick();
        check("rst_htrans", 64'(htrans), 64'd0);
        check("rst_haddr", 64'(haddr), 64'd0);
        check("rst_hwrite", 64'(hwrite), 64'd0);
        check("rst_hsize", 64'(hsize), 64'd0);
        check("rst_hwdata", 64'(hwdata), 64'd0);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp", 64'({rsp_valid, rsp_write, rsp_rdata, rsp_err}), 64'd0);
        hresetn = 1'b1;
        #1;
        check("cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
        tick();
        check("cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

        // single zero-wait write
        bus_addr.delete();
        bus_cyc.delete();
        send(1'b1, 8'h10, 3'd2, 32'hDEADBEEF, 32'h0, 1'b0, 1'b1);
        check("w1_idle_n", 64'(htrans), 64'd0);
        tick();
        check("w1_nonseq", 64'({htrans, haddr, hwrite, hsize}), 64'({2'b10, 8'h10, 1'b1, 3'd2}));
        tick();
        check("w1_hwdata", 64'(hwdata), 64'hDEADBEEF);
        check("w1_rsp_early", 64'(rsp_valid), 64'd0);
        tick();
        check("w1_rsp_valid", 64'(rsp_valid), 64'd1);
        drain();
        check("w1_bus_count", 64'(bus_addr.size()), 64'd1);

        // four back-to-back reads
        bus_addr.delete();
        bus_cyc.delete();
        for (int i = 0; i < 4; i++) begin
            send(1'b0, 8'(4 * i), 3'd2, 32'h0, 32'(i + 1), 1'b0, 1'b1);
        end
        drain();
        check("r4_bus_count", 64'(bus_addr.size()), 64'd4);
        for (int i = 1; i < 4 && i < bus_cyc.size(); i++) begin
            check("r4_nonseq_gap", 64'(bus_cyc[i] - bus_cyc[i-1]), 64'd1);
        end

        // write data phase stalled three cycles, second write held in address phase
        send(1'b1, 8'h30, 3'd2, 32'hA5A50001, 32'h0, 1'b0, 1'b1);
        send(1'b1, 8'h34, 3'd2, 32'h5A5A0002, 32'h0, 1'b0, 1'b1);
        tick();
        check("st_hwdata0", 64'(hwdata), 64'hA5A50001);
        hready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold", 64'({htrans, haddr, hwdata}), 64'({2'b10, 8'h34, 32'hA5A50001}));
        end
        check("st_rsp_early", 64'(rsp_valid), 64'd0);
        hready = 1'b1;
        tick();
        check("st_rsp_valid", 64'(rsp_valid), 64'd1);
        check("st_hwdata1", 64'(hwdata), 64'h5A5A0002);
        drain();

        // back-pressure: bounded outstanding transfers and full command FIFO
        bus_addr.delete();
        bus_cyc.delete();
        rsp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 8'(8'h20 + 4 * i), 3'd2, 32'h0, 32'(9 + i), 1'b0, 1'b1);
        end
        for (int i = 0; i < 10; i++) tick();
        check("bp_bus_count", 64'(bus_addr.size()), 64'd4);
        check("bp_cmd_ready", 64'(cmd_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        drain();
        check("bp_bus_total", 64'(bus_addr.size()), 64'd8);

        // oversized middle command never reaches the bus
        bus_addr.delete();
        bus_cyc.delete();
        send(1'b0, 8'h40, 3'd2, 32'h0, 32'h11, 1'b0, 1'b1);
        send(1'b0, 8'h44, 3'd3, 32'h0, 32'h0,  1'b1, 1'b1);
        send(1'b0, 8'h48, 3'd2, 32'h0, 32'h13, 1'b0, 1'b1);
        drain();
        check("sz_bus_count", 64'(bus_addr.size()), 64'd2);
        if (bus_addr.size() == 2) begin
            check("sz_bus_addr", 64'({bus_addr[0], bus_addr[1]}), 64'({8'h40, 8'h48}));
        end

`ifdef MINITB_AHB_MASTER_HRESP_EN
        // ERROR on the first of two reads
        bus_addr.delete();
        bus_cyc.delete();
        send(1'b0, 8'h50, 3'd2, 32'h0, 32'h0,  1'b1, 1'b1);
        send(1'b0, 8'h54, 3'd2, 32'h0, 32'h16, 1'b0, 1'b1);
        tick();
        check("er_second_nonseq", 64'({htrans, haddr}), 64'({2'b10, 8'h54}));
        hresp  = 1'b1;
        hready = 1'b0;
        tick();
        check("er_cancel_idle", 64'(htrans), 64'd0);
        hready = 1'b1;
        tick();
        check("er_reissue", 64'({htrans, haddr}), 64'({2'b10, 8'h54}));
        hresp = 1'b0;
        drain();
        check("er_bus_count", 64'(bus_addr.size()), 64'd2);
`endif

        // reset mid-transfer: outputs return to reset values, no response
        send(1'b1, 8'h60, 3'd2, 32'h12345678, 32'h0, 1'b0, 1'b0);
        tick();
        hresetn = 1'b0;
        #1;
        check("mr_outputs", 64'({htrans, haddr, hwrite, hsize, cmd_ready, rsp_valid}), 64'd0);
        tick();
        hresetn = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("mr_no_rsp", 64'({rsp_valid, htrans}), 64'd0);
        check("final_scoreboard", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
